// File: rtl/ysyx_24110015_ifu_pkg.sv
// Shared types and constants for the multi-cycle instruction fetch unit.
package ysyx_24110015_ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    OUT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [31:0] FAULT_INST = 32'h0;
  localparam int          PERF_W     = 32;

endpackage

// File: rtl/ysyx_24110015_ifu_perf.sv
// Fetch performance counters: completed instructions and bus-wait cycles.
// Both counters wrap modulo 2^32.
module ysyx_24110015_ifu_perf
  import ysyx_24110015_ifu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_inc,
  input  logic              stall_inc,
  output logic [PERF_W-1:0] fetch_cnt,
  output logic [PERF_W-1:0] stall_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_inc) fetch_cnt <= fetch_cnt + 1'b1;
      if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_24110015_ifu_fetch.sv
// Multi-cycle fetch stage: PC handshake -> AR/R read -> buffered instruction to IDU.
// Define YSYX_24110015_IFU_PERF_EN to add perf_fetch_cnt / perf_stall_cnt ports.
module ysyx_24110015_ifu_fetch
  import ysyx_24110015_ifu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RESP_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic [XLEN-1:0]   pc,
  input  logic              flush,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [XLEN-1:0]   mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [RESP_W-1:0] mem_rresp,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_fault
`ifdef YSYX_24110015_IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  ifu_state_e      state, state_next;
  logic [XLEN-1:0] pc_q, inst_q;
  logic            fault_q, drop;
  logic            pc_load, rsp_load, drop_set, misaligned;

  assign misaligned  = (pc[1:0] != 2'b00);
  assign pc_ready    = (state == IDLE);
  assign mem_arvalid = (state == AR);
  assign mem_rready  = (state == R);
  assign inst_valid  = (state == OUT);
  assign mem_araddr  = pc_q;
  assign inst_pc     = pc_q;
  assign inst        = inst_q;
  assign inst_fault  = fault_q;

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    rsp_load   = 1'b0;
    drop_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pc_valid) begin
          pc_load    = 1'b1;
          state_next = misaligned ? OUT : AR;
        end
      end
      AR: begin
        // arvalid must not be withdrawn, so a flush only marks the response as dead
        drop_set = flush;
        if (mem_arready) state_next = R;
      end
      R: begin
        drop_set = flush;
        if (mem_rvalid) begin
          if (drop || flush) begin
            state_next = IDLE;
          end else begin
            rsp_load   = 1'b1;
            state_next = OUT;
          end
        end
      end
      OUT: begin
        if (flush || inst_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
      drop    <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == IDLE) drop <= 1'b0;
      else if (drop_set)      drop <= 1'b1;
      if (pc_load) begin
        pc_q <= pc;
        // misaligned PCs skip the bus and go straight out as a fault
        if (misaligned) begin
          inst_q  <= XLEN'(FAULT_INST);
          fault_q <= 1'b1;
        end
      end
      if (rsp_load) begin
        inst_q  <= mem_rdata;
        fault_q <= (mem_rresp != RESP_W'(RESP_OKAY));
      end
    end
  end

`ifdef YSYX_24110015_IFU_PERF_EN
  ysyx_24110015_ifu_perf u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (inst_valid && inst_ready && !flush),
    .stall_inc ((state == AR) || (state == R)),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

endmodule
